// File: rtl/cnt_shift_ctrl.sv
// rtl/cnt_shift_ctrl.sv - Moore sequencer for the counter/shift-register serial-capture datapath
// Owns every datapath control; only si and co come back from the datapath side.

module cnt_shift_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic si,
  input  logic co,
  input  logic ack,
  output logic rst_sh,
  output logic init_sh,
  output logic en_sh,
  output logic rst_cnt,
  output logic ld,
  output logic en_cnt,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    CLR   = 3'd0,
    IDLE  = 3'd1,
    SHIFT = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = CLR;
    rst_sh    = 1'b0;
    init_sh   = 1'b0;
    en_sh     = 1'b0;
    rst_cnt   = 1'b0;
    ld        = 1'b0;
    en_cnt    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      CLR: begin
        rst_sh    = 1'b1;
        rst_cnt   = 1'b1;
        state_nxt = IDLE;
      end
      IDLE: begin
        ld        = 1'b1;
        init_sh   = 1'b1;
        state_nxt = si ? SHIFT : IDLE;
      end
      SHIFT: begin
        en_sh     = 1'b1;
        en_cnt    = 1'b1;
        busy      = 1'b1;
        state_nxt = co ? STOP : SHIFT;
      end
      STOP: begin
        busy      = 1'b1;
        state_nxt = si ? ERR : DONE;
      end
      DONE: begin
        // A start bit seen here is dropped; the consumer must ack first.
        done      = 1'b1;
        state_nxt = ack ? IDLE : DONE;
      end
      ERR: begin
        // A line still high after a bad stop bit forces a full clear.
        err       = 1'b1;
        state_nxt = si ? CLR : IDLE;
      end
      default: state_nxt = CLR;
    endcase
  end

endmodule
